process_scheduler: RTL

Round-robin preemptive scheduler for the multiprogrammed CPU. It counts a time quantum for the running process and, on expiry, yield or halt, runs the context switch:
- stalls the CPU;
- saves the current PC into the process control block;
- picks the next ready PID;
- loads that PID's saved PC and forces it into the CPU.

It sits between the Processador, the ProccessControlBlock and the BIOS loader, and drives the PID used by paging.

---
 rtl/process_scheduler_if.sv | 41 ++++
 rtl/process_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/process_scheduler_if.sv
// Scheduler-facing bundle: CPU, PCB and BIOS-loader handshakes plus the scheduled PID.
// master = scheduler side, slave = CPU/PCB/loader side.
interface process_scheduler_if #(
    parameter int unsigned NUM_PROC = 8
);
    localparam int unsigned PID_W = 5;
    localparam int unsigned PC_W  = 32;
    localparam int unsigned SW_W  = 16;

    logic                enable;
    logic [NUM_PROC-1:0] ready_mask;
    logic                yield;
    logic                halt;
    logic [PC_W-1:0]     pc_cpu;
    logic [PC_W-1:0]     load_pc;
    logic                load_valid;

    logic                stall;
    logic                save_req;
    logic [PID_W-1:0]    save_pid;
    logic [PC_W-1:0]     save_pc;
    logic                load_req;
    logic [PID_W-1:0]    load_pid;
    logic                pc_load;
    logic [PC_W-1:0]     pc_new;
    logic [PID_W-1:0]    pid;
    logic                idle;
    logic [SW_W-1:0]     switch_count;

    modport master (
        input  enable, ready_mask, yield, halt, pc_cpu, load_pc, load_valid,
        output stall, save_req, save_pid, save_pc, load_req, load_pid,
               pc_load, pc_new, pid, idle, switch_count
    );

    modport slave (
        output enable, ready_mask, yield, halt, pc_cpu, load_pc, load_valid,
        input  stall, save_req, save_pid, save_pc, load_req, load_pid,
               pc_load, pc_new, pid, idle, switch_count
    );
endinterface

// File: rtl/process_scheduler.sv
// Round-robin preemptive process scheduler: quantum timer plus save/select/load/resume context switch.
// Optional SCHED_WATCHDOG_EN: abandon a LOAD after 16 cycles without LoadValid and retire that PID.
module process_scheduler #(
    parameter int unsigned NUM_PROC = 8,
    parameter int unsigned QUANTUM  = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    process_scheduler_if.master  bus
);
    localparam int unsigned PID_W = 5;
    localparam int unsigned PC_W  = 32;
    localparam int unsigned SW_W  = 16;
    localparam int unsigned CNT_W = $clog2(QUANTUM);
    localparam logic [NUM_PROC-1:0] ONE = NUM_PROC'(1);
`ifdef SCHED_WATCHDOG_EN
    localparam int unsigned WD_W     = 4;
    localparam int unsigned WD_LIMIT = 16;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_SAVE,
        ST_SELECT,
        ST_LOAD,
        ST_RESUME
    } state_t;

    state_t              state_q, state_d;
    logic [PID_W-1:0]    pid_q, pid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_PROC-1:0] done_q, done_d;
    logic                scan_zero_q, scan_zero_d;
    logic [SW_W-1:0]     switch_q, switch_d;
    logic                stall_q, stall_d;
    logic                idle_q, idle_d;
    logic                save_req_q, save_req_d;
    logic [PID_W-1:0]    save_pid_q, save_pid_d;
    logic [PC_W-1:0]     save_pc_q, save_pc_d;
    logic                load_req_q, load_req_d;
    logic [PID_W-1:0]    load_pid_q, load_pid_d;
    logic                pc_load_q, pc_load_d;
    logic [PC_W-1:0]     pc_new_q, pc_new_d;
`ifdef SCHED_WATCHDOG_EN
    logic [WD_W-1:0]     wd_q, wd_d;
`endif

    logic [NUM_PROC-1:0] eligible;
    logic                sel_found;
    logic [PID_W-1:0]    sel_pid;
    int unsigned         scan_base;
    int unsigned         idx;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pid_q       <= '0;
            cnt_q       <= '0;
            done_q      <= '0;
            scan_zero_q <= 1'b1;
            switch_q    <= '0;
            stall_q     <= 1'b1;
            idle_q      <= 1'b1;
            save_req_q  <= 1'b0;
            save_pid_q  <= '0;
            save_pc_q   <= '0;
            load_req_q  <= 1'b0;
            load_pid_q  <= '0;
            pc_load_q   <= 1'b0;
            pc_new_q    <= '0;
`ifdef SCHED_WATCHDOG_EN
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pid_q       <= pid_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            scan_zero_q <= scan_zero_d;
            switch_q    <= switch_d;
            stall_q     <= stall_d;
            idle_q      <= idle_d;
            save_req_q  <= save_req_d;
            save_pid_q  <= save_pid_d;
            save_pc_q   <= save_pc_d;
            load_req_q  <= load_req_d;
            load_pid_q  <= load_pid_d;
            pc_load_q   <= pc_load_d;
            pc_new_q    <= pc_new_d;
`ifdef SCHED_WATCHDOG_EN
            wd_q        <= wd_d;
`endif
        end
    end

    // Next-state, round-robin pick and next output values
    always_comb begin
        state_d     = state_q;
        pid_d       = pid_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        scan_zero_d = scan_zero_q;
        switch_d    = switch_q;
        save_pid_d  = save_pid_q;
        save_pc_d   = save_pc_q;
        load_pid_d  = load_pid_q;
        pc_new_d    = pc_new_q;
`ifdef SCHED_WATCHDOG_EN
        wd_d        = '0;
`endif

        // Scan from PID+1 with wrap so the current PID is considered last
        eligible  = bus.ready_mask & ~done_q;
        sel_found = 1'b0;
        sel_pid   = '0;
        scan_base = scan_zero_q ? 32'd0 : (32'(pid_q) + 32'd1);
        idx       = 32'd0;
        for (int unsigned i = 0; i < NUM_PROC; i++) begin
            idx = (scan_base + i) % NUM_PROC;
            if (!sel_found && (|(eligible & (ONE << idx)))) begin
                sel_found = 1'b1;
                sel_pid   = PID_W'(idx);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.enable && (|eligible)) begin
                    state_d     = ST_SELECT;
                    scan_zero_d = 1'b1;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.halt) begin
                    done_d      = done_q | (ONE << pid_q);
                    scan_zero_d = 1'b0;
                    state_d     = ST_SELECT;
                end else if ((cnt_q == CNT_W'(QUANTUM - 1)) || bus.yield || !bus.enable) begin
                    save_pid_d  = pid_q;
                    save_pc_d   = bus.pc_cpu;
                    scan_zero_d = 1'b0;
                    state_d     = ST_SAVE;
                end
            end
            ST_SAVE: begin
                state_d = bus.enable ? ST_SELECT : ST_IDLE;
            end
            ST_SELECT: begin
                if (sel_found) begin
                    load_pid_d = sel_pid;
                    state_d    = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
`ifdef SCHED_WATCHDOG_EN
                wd_d = wd_q + WD_W'(1);
`endif
                if (bus.load_valid) begin
                    pc_new_d = bus.load_pc;
                    state_d  = ST_RESUME;
                end
`ifdef SCHED_WATCHDOG_EN
                else if (wd_q == WD_W'(WD_LIMIT - 1)) begin
                    done_d  = done_q | (ONE << load_pid_q);
                    state_d = ST_SELECT;
                end
`endif
            end
            ST_RESUME: begin
                pid_d    = load_pid_q;
                cnt_d    = '0;
                switch_d = switch_q + SW_W'(1);
                state_d  = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs registered against the state being entered so they align with it
        stall_d    = (state_d != ST_RUN);
        idle_d     = (state_d == ST_IDLE);
        save_req_d = (state_d == ST_SAVE);
        load_req_d = (state_d == ST_LOAD) && (state_q != ST_LOAD);
        pc_load_d  = (state_d == ST_RESUME);
    end

    assign bus.stall        = stall_q;
    assign bus.idle         = idle_q;
    assign bus.save_req     = save_req_q;
    assign bus.save_pid     = save_pid_q;
    assign bus.save_pc      = save_pc_q;
    assign bus.load_req     = load_req_q;
    assign bus.load_pid     = load_pid_q;
    assign bus.pc_load      = pc_load_q;
    assign bus.pc_new       = pc_new_q;
    assign bus.pid          = pid_q;
    assign bus.switch_count = switch_q;
endmodule
